// File: rtl/wb_axisin_pkg.sv
// Shared address map, FSM encoding and status-word layout for the Wishbone-to-AXI-Stream input bridge.
package wb_axisin_pkg;

  localparam logic [7:0] ADDR_PUSH      = 8'h80;
  localparam logic [7:0] ADDR_PUSH_LAST = 8'h8C;
  localparam logic [7:0] ADDR_STATUS    = 8'h88;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_ACK        = 2'd2
  } state_e;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_CNT_LSB   = 8;

  function automatic logic [31:0] status_word(input logic empty, input logic full,
                                              input logic [7:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_EMPTY_BIT]      = empty;
    w[STAT_FULL_BIT]       = full;
    w[STAT_CNT_LSB +: 8]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/wb_axisin_if.sv
// Wishbone slave request/response plus the FIR-facing AXI-Stream beat, bundled for the bridge.
interface wb_axisin_if #(
  parameter int pDATA_WIDTH = 32
);
  logic                   wbs_stb_i;
  logic                   wbs_cyc_i;
  logic                   wbs_we_i;
  logic [3:0]             wbs_sel_i;
  logic [31:0]            wbs_dat_i;
  logic [31:0]            wbs_adr_i;
  logic                   wbs_ack_o;
  logic [31:0]            wbs_dat_o;
  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, ss_tready,
    output wbs_ack_o, wbs_dat_o, ss_tvalid, ss_tdata, ss_tlast
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, ss_tready,
    input  wbs_ack_o, wbs_dat_o, ss_tvalid, ss_tdata, ss_tlast
  );
endinterface

// File: rtl/wb_axisin_fifo.sv
// Synchronous FIFO with registered pointers and combinational head; push+pop in one cycle is legal even
// when full. The caller guarantees no push into a full FIFO without a pop and no pop when empty.
module wb_axisin_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    count_d  = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through a nonzero count.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/wb_axisin.sv
// Wishbone writes to 0x80/0x8C become AXI-Stream beats via a FIFO; ack one cycle after the push, a full
// FIFO stalls the ack until a pop frees space. Status read at 0x88 only when WB_AXISIN_STATUS_EN is defined.
module wb_axisin
  import wb_axisin_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  wb_axisin_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic             req, push_req, stat_req;
  logic             push, pop, load_stat;
  logic [7:0]       adr8;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic [pDATA_WIDTH:0] fifo_head;

  assign req      = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign adr8     = bus.wbs_adr_i[7:0];
  assign push_req = req & bus.wbs_we_i & ((adr8 == ADDR_PUSH) | (adr8 == ADDR_PUSH_LAST));
  assign pop      = ~fifo_empty & bus.ss_tready;

  // A same-cycle pop frees the slot this push needs, so full alone does not stall.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    load_stat = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (push_req) begin
          if (!fifo_full || pop) begin
            push    = 1'b1;
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT_SPACE;
          end
        end else if (stat_req) begin
          load_stat = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_WAIT_SPACE: begin
        if (!push_req) begin
          state_d = ST_IDLE;
        end else if (!fifo_full || pop) begin
          push    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  wb_axisin_fifo #(
    .WIDTH (pDATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rst_ni),
    .push_i     (push),
    .push_dat_i ({adr8 == ADDR_PUSH_LAST, pDATA_WIDTH'(bus.wbs_dat_i)}),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign bus.wbs_ack_o = (state_q == ST_ACK);
  assign bus.ss_tvalid = ~fifo_empty;
  assign bus.ss_tlast  = ~fifo_empty & fifo_head[pDATA_WIDTH];
  assign bus.ss_tdata  = fifo_empty ? '0 : fifo_head[pDATA_WIDTH-1:0];

`ifdef WB_AXISIN_STATUS_EN
  logic [31:0] dat_q, dat_d;

  assign stat_req = req & ~bus.wbs_we_i & (adr8 == ADDR_STATUS);
  assign dat_d    = load_stat ? status_word(fifo_empty, fifo_full, 8'(fifo_cnt)) : '0;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) dat_q <= '0;
    else            dat_q <= dat_d;
  end

  assign bus.wbs_dat_o = dat_q;

  logic unused_ok;
  assign unused_ok = ^{bus.wbs_sel_i, bus.wbs_adr_i[31:8], 32'(pADDR_WIDTH)};
`else
  assign stat_req      = 1'b0;
  assign bus.wbs_dat_o = '0;

  logic unused_ok;
  assign unused_ok = ^{bus.wbs_sel_i, bus.wbs_adr_i[31:8], 32'(pADDR_WIDTH), fifo_cnt, load_stat};
`endif
endmodule
